// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage with a stalling single-outstanding bus port.
//
// Purpose:
//   An ALU op (no memory access) passes straight into the MEM/WB register.
//   An aligned load or store raises a registered bus request and holds it until
//   mem_ack arrives. While it waits, stall freezes EX/MEM and every stage upstream,
//   and MEM/WB receives bubbles. The completed instruction then retires from MEM/WB
//   in a one-cycle DONE step.
//   The stage flags a fault, without issuing a bus request, in two cases:
//     - a misaligned access;
//     - a request with both MemRead and MemWrite set.
//   It also flags a fault when no ack arrives within TIMEOUT BUSY cycles.
//
// Parameters:
//   TIMEOUT      maximum number of BUSY cycles spent waiting for mem_ack
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   WB[1:0]      {RegWrite, MemtoReg} from EX/MEM
//   M[2:0]       {Branch, MemRead, MemWrite} from EX/MEM (Branch unused here)
//   ALUOut       effective address / ALU result
//   WriteData    store data
//   RegRD        destination register
//   stall        combinational; 1 freezes EX/MEM and upstream stages
//   mem_req      registered bus request
//   mem_we       registered bus write strobe
//   mem_addr     registered bus address
//   mem_wdata    registered bus store data
//   mem_rdata    bus read data
//   mem_ack      bus one-cycle completion strobe
//   mem_fault    registered one-cycle fault pulse
//   WBreg, ReadDataReg, ALUreg, RegRDreg   MEM/WB pipeline register
module mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteData,
    input  logic [4:0]  RegRD,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_fault,
    output logic [1:0]  WBreg,
    output logic [31:0] ReadDataReg,
    output logic [31:0] ALUreg,
    output logic [4:0]  RegRDreg
);

    // Wide enough to hold TIMEOUT itself without wrapping.
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nx;

    logic          mem_read;
    logic          mem_write;
    logic          access;
    logic          aligned;
    logic          bad_op;
    logic          start;
    logic          timeout;
    logic          unused_branch;

    logic [CW-1:0] cnt;

    logic [1:0]    hold_wb;
    logic [31:0]   hold_alu;
    logic [31:0]   hold_data;
    logic [4:0]    hold_rd;

    assign mem_read      = M[1];
    assign mem_write     = M[0];
    assign unused_branch = M[2];

    assign access  = mem_read ^ mem_write;
    assign aligned = (ALUOut[1:0] == 2'b00);
    // Both strobes set, or a misaligned single access, becomes a fault
    // instead of a bus request.
    assign bad_op  = (mem_read & mem_write) | (access & ~aligned);
    assign start   = access & aligned;
    // The counter value reaches TIMEOUT at the edge where this is true. An ack
    // that arrives on that same cycle is checked first and takes precedence.
    assign timeout = (cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = BUSY;
            BUSY:    if (mem_ack || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = start;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Bus port, hold registers, counter and MEM/WB register
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_fault   <= 1'b0;
            WBreg       <= '0;
            ReadDataReg <= '0;
            ALUreg      <= '0;
            RegRDreg    <= '0;
            hold_wb     <= '0;
            hold_alu    <= '0;
            hold_data   <= '0;
            hold_rd     <= '0;
            cnt         <= '0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (bad_op) begin
                        mem_fault   <= 1'b1;
                        WBreg       <= '0;
                        ALUreg      <= ALUOut;
                        RegRDreg    <= RegRD;
                        ReadDataReg <= '0;
                    end else if (start) begin
                        hold_wb     <= WB;
                        hold_alu    <= ALUOut;
                        hold_rd     <= RegRD;
                        hold_data   <= '0;
                        mem_req     <= 1'b1;
                        mem_we      <= mem_write;
                        mem_addr    <= ALUOut;
                        mem_wdata   <= WriteData;
                        cnt         <= '0;
                        WBreg       <= '0;
                        ALUreg      <= '0;
                        RegRDreg    <= '0;
                        ReadDataReg <= '0;
                    end else begin
                        WBreg       <= WB;
                        ALUreg      <= ALUOut;
                        RegRDreg    <= RegRD;
                        ReadDataReg <= '0;
                    end
                end
                BUSY: begin
                    WBreg       <= '0;
                    ALUreg      <= '0;
                    RegRDreg    <= '0;
                    ReadDataReg <= '0;
                    cnt         <= cnt + 1'b1;
                    if (mem_ack) begin
                        hold_data <= mem_we ? '0 : mem_rdata;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                    end else if (timeout) begin
                        // The instruction still retires through DONE, but
                        // with its register write suppressed.
                        hold_wb   <= '0;
                        hold_data <= '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_fault <= 1'b1;
                    end
                end
                DONE: begin
                    WBreg       <= hold_wb;
                    ALUreg      <= hold_alu;
                    RegRDreg    <= hold_rd;
                    ReadDataReg <= hold_data;
                end
                default: begin
                    WBreg       <= '0;
                    ALUreg      <= '0;
                    RegRDreg    <= '0;
                    ReadDataReg <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning: max BUSY cycles waiting for mem_ack before fault.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 WB  in  2  {RegWrite, MemtoReg} from EX/MEM register.
REQ-005 M  in  3  {Branch, MemRead, MemWrite} from EX/MEM register; Branch unused here.
REQ-006 ALUOut  in  32  effective address / ALU result.
REQ-007 WriteData  in  32  store data.
REQ-008 RegRD  in  5  destination register.
REQ-009 stall  out  1  combinational; 1 freezes EX/MEM and all upstream stages.
REQ-010 mem_req, mem_we  out  1 each  registered bus request and write strobe.
REQ-011 mem_addr, mem_wdata  out  32 each  registered bus address and store data.
REQ-012 mem_rdata  in  32; mem_ack  in  1  bus read data, one-cycle completion strobe.
REQ-013 mem_fault  out  1  registered one-cycle fault pulse.
REQ-014 WBreg  out  2; ReadDataReg  out  32; ALUreg  out  32; RegRDreg  out  5  MEM/WB register.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 access = MemRead XOR MemWrite, evaluated in IDLE only.
REQ-017 stall SHALL equal (IDLE and access and ALUOut[1:0]==0) or BUSY; 0 in DONE.
REQ-018 IDLE, no access: MEM/WB loads WB, ALUOut, RegRD, ReadDataReg=0; latency 1 cycle; no stall.
REQ-019 IDLE, aligned access: latch WB, ALUOut, WriteData, RegRD, MemWrite into hold regs; next edge mem_req=1, mem_we=MemWrite, mem_addr=ALUOut, mem_wdata=WriteData; go BUSY; MEM/WB loads bubble (all zero).
REQ-020 BUSY: mem_req/mem_addr/mem_wdata/mem_we held constant; MEM/WB loads bubble each cycle; cycle counter increments.
REQ-021 BUSY with mem_ack=1: capture mem_rdata (read) or 0 (write) into hold; mem_req=0 next edge; go DONE.
REQ-022 DONE (exactly 1 cycle): MEM/WB loads held WB, ALUOut, RegRD, captured data; go IDLE; stall=0 lets EX/MEM advance past the completed instruction.
REQ-023 Minimum memory-op occupancy: IDLE + 1 BUSY + DONE = 3 cycles for ack on first BUSY cycle.
REQ-024 Misaligned access (ALUOut[1:0]!=0): no bus request, no stall, mem_fault=1 for one cycle, MEM/WB loads RegRD/ALUOut with WBreg=0.
REQ-025 MemRead and MemWrite both 1: treated as fault exactly as REQ-024.
REQ-026 Timeout: BUSY counter reaching TIMEOUT without ack -> drop mem_req, mem_fault=1 for one cycle, go DONE with WBreg forced 0.
REQ-027 mem_ack outside BUSY SHALL be ignored; ack coincident with timeout SHALL win (normal completion).
REQ-028 Counter width SHALL hold TIMEOUT without wrap; cleared on entry to BUSY.

Reset
REQ-029 reset SHALL force IDLE, clear hold regs and counter; next edge: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_fault=0, WBreg=0, ReadDataReg=0, ALUreg=0, RegRDreg=0.
REQ-030 reset during BUSY/DONE SHALL abandon the access; late mem_ack SHALL be ignored.
REQ-031 stall SHALL be 0 during the reset cycle's following cycle unless a new access is presented.

Verification
REQ-032 ALU op: WB=2'b10, M=0, ALUOut=0x1234, RegRD=5 -> next cycle WBreg=2'b10, ALUreg=0x1234, RegRDreg=5, ReadDataReg=0, stall never 1.
REQ-033 Load: M=3'b010, ALUOut=0x100, ack after 3 BUSY cycles with rdata=0xDEADBEEF -> mem_req high 3 cycles at addr 0x100, stall high 4 cycles, then ReadDataReg=0xDEADBEEF, WBreg=WB, RegRDreg=RegRD.
REQ-034 Store: M=3'b001, ALUOut=0x200, WriteData=0xCAFE, immediate ack -> mem_we=1, mem_wdata=0xCAFE for 1 cycle; stall 2 cycles; ReadDataReg=0.
REQ-035 Misaligned load ALUOut=0x102 -> mem_fault pulse, mem_req stays 0, WBreg=0, stall 0.
REQ-036 Timeout TIMEOUT=4, no ack -> mem_req high 4 cycles, mem_fault pulse, WBreg=0, FSM back to IDLE after DONE.
REQ-037 reset asserted in 2nd BUSY cycle, then ack -> all outputs 0, state IDLE, ack ignored.
